// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory port arbiter.
// Optional readback path is enabled by defining IMEM_ARB_READBACK_EN.
package imem_arb_pkg;

  localparam int unsigned LEN_ADDR  = 32;
  localparam int unsigned LEN_DATA  = 32;
  localparam int unsigned RAM_DEPTH = 2048;
  localparam int unsigned CNT_W     = $clog2(RAM_DEPTH) + 1;

  // Cycles spent letting the last accepted fetch read complete before LOAD.
  localparam int unsigned DRAIN_LEN = 1;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } arb_state_e;

  function automatic logic addr_in_range(input logic [LEN_ADDR-1:0] addr);
    return addr < LEN_ADDR'(RAM_DEPTH);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and RAM-side signals of the instruction-memory arbiter.
// Readback signals exist only when IMEM_ARB_READBACK_EN is defined.
interface imem_arbiter_if
  import imem_arb_pkg::*;
();

  logic                fetch_en;
  logic [LEN_ADDR-1:0] fetch_addr;
  logic                fetch_stall;
  logic                fetch_valid;
  logic [LEN_DATA-1:0] fetch_data;

  logic                ld_req;
  logic                ld_gnt;
  logic                ld_valid;
  logic [LEN_ADDR-1:0] ld_addr;
  logic [LEN_DATA-1:0] ld_data;
  logic                ld_ready;
  logic                ld_done;
  logic                ld_err;
  logic [CNT_W-1:0]    ld_count;

  logic [LEN_ADDR-1:0] mem_addr;
  logic                mem_we;
  logic [LEN_DATA-1:0] mem_wdata;
  logic [LEN_DATA-1:0] mem_rdata;

`ifdef IMEM_ARB_READBACK_EN
  logic                rb_en;
  logic [LEN_DATA-1:0] rb_data;
  logic                rb_valid;
`endif

  // Arbiter side.
  modport slave (
`ifdef IMEM_ARB_READBACK_EN
    input  rb_en,
    output rb_data, rb_valid,
`endif
    input  fetch_en, fetch_addr,
    output fetch_stall, fetch_valid, fetch_data,
    input  ld_req, ld_valid, ld_addr, ld_data, ld_done,
    output ld_gnt, ld_ready, ld_err, ld_count,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  // Requester / RAM side.
  modport master (
`ifdef IMEM_ARB_READBACK_EN
    output rb_en,
    input  rb_data, rb_valid,
`endif
    output fetch_en, fetch_addr,
    input  fetch_stall, fetch_valid, fetch_data,
    output ld_req, ld_valid, ld_addr, ld_data, ld_done,
    input  ld_gnt, ld_ready, ld_err, ld_count,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/imem_ld_counter.sv
// Per-grant loader statistics: saturating count of in-range words written
// and a sticky flag for rejected out-of-range writes.
module imem_ld_counter
  import imem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             err_set_i,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (clear_i) begin
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (inc_i && (count_q != CNT_W'(RAM_DEPTH))) begin
        count_d = count_q + CNT_W'(1);
      end
      if (err_set_i) begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction RAM port between the fetch stage and the program loader.
// Define IMEM_ARB_READBACK_EN to add loader readback of RAM words during LOAD.
module imem_arbiter
  import imem_arb_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  imem_arbiter_if.slave  bus
);

  arb_state_e          state_q;
  logic [DRAIN_W-1:0]  drain_cnt_q;
  logic [LEN_ADDR-1:0] last_addr_q;
  logic                fetch_valid_q;

  logic in_load;
  logic ld_in_range;
  logic fetch_stall;

  assign in_load     = (state_q == LOAD);
  assign ld_in_range = addr_in_range(bus.ld_addr);
  assign fetch_stall = (state_q != RUN);

  // FSM plus the address captured for DRAIN and the registered fetch handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      drain_cnt_q   <= '0;
      last_addr_q   <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= bus.fetch_en & ~fetch_stall;
      unique case (state_q)
        RUN: begin
          last_addr_q <= bus.fetch_addr;
          drain_cnt_q <= '0;
          if (bus.ld_req) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_W'(DRAIN_LEN - 1)) begin
            state_q <= LOAD;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
          end
        end
        LOAD: begin
          // Only ld_done releases the port; dropping ld_req alone is ignored.
          if (bus.ld_done) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // RAM port mux: purely combinational so an async reset removes mem_we at once.
  always_comb begin
    bus.mem_addr  = bus.fetch_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    unique case (state_q)
      RUN:   bus.mem_addr = bus.fetch_addr;
      DRAIN: bus.mem_addr = last_addr_q;
      LOAD: begin
        bus.mem_addr  = bus.ld_addr;
        bus.mem_wdata = bus.ld_data;
        bus.mem_we    = bus.ld_valid & ld_in_range;
      end
      default: bus.mem_addr = bus.fetch_addr;
    endcase
  end

  assign bus.fetch_stall = fetch_stall;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_data  = bus.mem_rdata;
  assign bus.ld_gnt      = in_load;
  assign bus.ld_ready    = in_load;

  imem_ld_counter u_ld_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == DRAIN),
    .inc_i     (in_load & bus.ld_valid & ld_in_range),
    .err_set_i (in_load & bus.ld_valid & ~ld_in_range),
    .count_o   (bus.ld_count),
    .err_o     (bus.ld_err)
  );

`ifdef IMEM_ARB_READBACK_EN
  logic rb_valid_q;

  // A write offered in the same cycle takes precedence over a readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= in_load & bus.rb_en & ~bus.ld_valid;
    end
  end

  assign bus.rb_valid = rb_valid_q;
  assign bus.rb_data  = bus.mem_rdata;
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single port of the instruction memory between the pipeline fetch stage and the program loader (debug/UART unit). In run mode the fetch stage reads instructions each cycle; on loader request the arbiter drains the in-flight read, stalls fetch, grants the port to the loader for word writes, then returns it to fetch. It sits between IF stage, loader and the instruction RAM, and drives the RAM address/write-enable mux.

## Interface
- len_addr, 32, width of word address (word index, not byte address)
- len_data, 32, instruction word width
- ram_depth, 2048, number of memory entries; writes at addr >= ram_depth are rejected
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  fetch stage requests a read this cycle
- fetch_addr  in  len_addr  PC word index
- fetch_stall  out  1  fetch not accepted this cycle
- fetch_valid  out  1  fetch_data holds the word for the read accepted last cycle
- fetch_data  out  len_data  instruction word (mem_rdata passthrough)
- ld_req  in  1  loader requests the port (level)
- ld_gnt  out  1  loader owns the port
- ld_valid  in  1  write word offered
- ld_addr  in  len_addr  write word index
- ld_data  in  len_data  write data
- ld_ready  out  1  write accepted when ld_valid & ld_ready
- ld_done  in  1  loader releases the port
- ld_err  out  1  sticky: an out-of-range write was rejected
- ld_count  out  $clog2(ram_depth)+1  in-range words written in current grant
- mem_addr  out  len_addr  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  len_data  RAM write data
- mem_rdata  in  len_data  RAM read data (RAM registers address, 1-cycle read)

## Operation
- States: RUN, DRAIN, LOAD. Reset -> RUN.
- RUN: mem_addr=fetch_addr, mem_we=0, fetch_stall=0, ld_gnt=0, ld_ready=0. ld_req sampled high -> DRAIN; ld_req has priority, fetch in that same cycle is still accepted.
- DRAIN (exactly 1 cycle): fetch_stall=1, mem_we=0, mem_addr holds last fetch_addr; completes last read. Clears ld_count and ld_err. -> LOAD.
- LOAD: ld_gnt=1, ld_ready=1, fetch_stall=1, mem_addr=ld_addr, mem_wdata=ld_data, mem_we=ld_valid & (ld_addr < ram_depth). Out-of-range accepted write: no RAM write, ld_err set. In-range write increments ld_count, saturating at ram_depth. ld_done high -> RUN next cycle; ld_done with ld_valid same cycle: write performed, then exit.
- ld_req dropping in LOAD without ld_done: stay in LOAD (ld_done is the only release).
- fetch_valid registered: 1 the cycle after fetch_en & ~fetch_stall, else 0.
- ld_count and ld_err hold their values in RUN until next DRAIN.

## Timing
- Reset values: state RUN, fetch_valid 0, ld_count 0, ld_err 0; hence fetch_stall 0, ld_gnt 0, ld_ready 0, mem_we 0, mem_addr=fetch_addr.
- Reset asserted mid-LOAD: state -> RUN asynchronously, mem_we drops immediately, no partial write.
- Fetch latency 1 cycle. Grant latency from ld_req: 2 cycles (DRAIN, then LOAD). Release: fetch resumes the cycle after ld_done sampled.
- Write throughput: one word per cycle in LOAD.
- All outputs except fetch_valid, ld_count, ld_err are combinational from state and inputs.

## Configuration
- IMEM_ARB_READBACK_EN defined: adds ports rb_en (in 1), rb_data (out len_data), rb_valid (out 1). In LOAD with ld_valid=0 and rb_en=1, mem_addr=ld_addr and rb_valid asserts next cycle with rb_data=mem_rdata. rb_en with ld_valid same cycle: write wins, no readback.
- Not defined: ports absent, LOAD reads ignored.

## Structure
- Package imem_arb_pkg: state enum (RUN=2'd0, DRAIN=2'd1, LOAD=2'd2), DRAIN length constant.
- One sub-module: imem_ld_counter (saturating ld_count with clear and sticky ld_err).

## Test plan
- Reset, fetch_en=1, fetch_addr 0..3 with RAM preloaded -> fetch_valid from cycle 1, fetch_data = words 0..3, no stall.
- ld_req during fetch of addr 5 -> word 5 delivered in DRAIN, fetch_stall=1 for DRAIN+LOAD, ld_gnt high 2 cycles after ld_req.
- Load 4 words at addr 0x10..0x13, then ld_done -> ld_count=4, ld_err=0, fetch of 0x10 returns loaded data.
- Write to addr 2048 -> mem_we=0, ld_err=1, ld_count unchanged; next grant clears ld_err.
- rst_n low mid-LOAD with ld_valid=1 -> mem_we 0 immediately, state RUN, ld_gnt 0, target word unchanged.
- ld_done with ld_valid on last word -> word written, RUN next cycle, fetch_stall 0.
